// File: rtl/des_pkg.sv
// DES key-schedule shared definitions: PC-1/PC-2 permutations, forward shift schedule, FSM states.
// Latency: pure functions and constants, no state.
// Backpressure: not applicable.
// Bit numbering follows FIPS 46-3: index 1 is the MSB of every vector.
package des_pkg;

    // Left-rotate amounts for forward rounds 1..16 (entry 0 is round 1).
    localparam logic [1:0] SHIFT_FWD [0:15] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // PC-1, C half. Parity bits 8,16,...,64 are dropped.
    function automatic logic [1:28] pc1_c(input logic [1:64] key);
        return {key[57], key[49], key[41], key[33], key[25], key[17], key[9],
                key[1],  key[58], key[50], key[42], key[34], key[26], key[18],
                key[10], key[2],  key[59], key[51], key[43], key[35], key[27],
                key[19], key[11], key[3],  key[60], key[52], key[44], key[36]};
    endfunction

    // PC-1, D half.
    function automatic logic [1:28] pc1_d(input logic [1:64] key);
        return {key[63], key[55], key[47], key[39], key[31], key[23], key[15],
                key[7],  key[62], key[54], key[46], key[38], key[30], key[22],
                key[14], key[6],  key[61], key[53], key[45], key[37], key[29],
                key[21], key[13], key[5],  key[28], key[20], key[12], key[4]};
    endfunction

    // PC-2: 56-bit CD register to 48-bit round subkey.
    function automatic logic [1:48] pc2(input logic [1:56] cd);
        return {cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],
                cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
                cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],
                cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
                cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
                cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
                cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
                cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]};
    endfunction

    // Right-rotate amount applied when the issued-key count becomes cnt_nxt (1..15).
    // Stepping from K(17-j) back to K(16-j) undoes forward round 17-j, i.e.
    // SHIFT_FWD[16-j]; 16-j modulo 16 is simply the 4-bit negation of j.
    // Returns 1 for a 2-bit rotation, 0 for a 1-bit rotation.
    function automatic logic rshift_by2(input logic [3:0] cnt_nxt);
        logic [3:0] idx;
        idx = 4'd0 - cnt_nxt;
        return SHIFT_FWD[idx] == 2'd2;
    endfunction

endpackage

// File: rtl/des_keygen_dec_if.sv
// Handshake bundle between a decrypt-mode DES round core and its reverse key schedule.
// Latency: wires only.
// Backpressure: consumer holds next low to stall; the current subkey stays presented.
// master: consumer side (drives start/key/next); slave: key schedule side.
interface des_keygen_dec_if;
    logic        start;
    logic [1:64] key;
    logic        next;
    logic        busy;
    logic        out_valid;
    logic [3:0]  kidx;
    logic [1:48] Kn;
    logic        done;

    modport master (
        output start, key, next,
        input  busy, out_valid, kidx, Kn, done
    );

    modport slave (
        input  start, key, next,
        output busy, out_valid, kidx, Kn, done
    );
endinterface

// File: rtl/des_cd_rotr.sv
// Right rotation of the C and D halves (each 28 bits, independently) of the DES CD register.
// Latency: combinational.
// Backpressure: not applicable.
// Ports: cd_in[1:56] current CD, by2 (0: rotate by 1, 1: rotate by 2), cd_out[1:56] rotated CD.
module des_cd_rotr (
    input  logic [1:56] cd_in,
    input  logic        by2,
    output logic [1:56] cd_out
);

    logic [1:28] c;
    logic [1:28] d;

    assign c = cd_in[1:28];
    assign d = cd_in[29:56];

    assign cd_out = by2 ? {c[27:28], c[1:26], d[27:28], d[1:26]}
                        : {c[28],    c[1:27], d[28],    d[1:27]};

endmodule

// File: rtl/des_keygen_dec.sv
// Decrypt-direction DES key schedule: issues K16 down to K1 from one loaded key.
// Latency: K16 valid the cycle after start is accepted; one key per cycle with next held high.
// Backpressure: next low holds CD, cnt and the presented subkey indefinitely.
// Ports: clk, rst_n (async, active-low); bus (slave): start/key in, next in,
//        busy/out_valid/kidx/Kn/done out. Kn is PC-2 of the CD register, unpipelined.
import des_pkg::*;

module des_keygen_dec (
    input  logic              clk,
    input  logic              rst_n,
    des_keygen_dec_if.slave   bus
);

    state_t      state;
    state_t      state_nxt;
    logic [1:56] cd;
    logic [1:56] cd_nxt;
    logic [1:56] cd_rot;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [3:0]  cnt_inc;

    assign cnt_inc = cnt + 4'd1;

    // The forward schedule rotates left 28 bits in total, so C0D0 already
    // equals C16D16: K16 needs no rotation, and each advance rotates right.
    des_cd_rotr u_rotr (
        .cd_in  (cd),
        .by2    (rshift_by2(cnt_inc)),
        .cd_out (cd_rot)
    );

    always_comb begin
        state_nxt = state;
        cd_nxt    = cd;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    cd_nxt    = {pc1_c(bus.key), pc1_d(bus.key)};
                    cnt_nxt   = 4'd0;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.next) begin
                    if (cnt == 4'd15) begin
                        // K1 consumed; CD is deliberately left untouched.
                        state_nxt = ST_DONE;
                    end else begin
                        cd_nxt  = cd_rot;
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cd    <= '0;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cd    <= cd_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign bus.busy      = (state == ST_ISSUE) || (state == ST_DONE);
    assign bus.out_valid = (state == ST_ISSUE);
    assign bus.done      = (state == ST_DONE);
    assign bus.kidx      = 4'd15 - cnt;
    assign bus.Kn        = pc2(cd);

endmodule

// File: doc/des_keygen_dec.md
# des_keygen_dec

Decryption-direction DES key schedule. It loads a 64-bit key and applies PC-1. It then issues the 16 round subkeys in reverse order, K16 first and K1 last, by rotating C and D right. A consumer pulls each key with a `next` handshake. The block sits beside the DES round core and feeds its subkey input when the core runs in decrypt mode.

## Interface
Parameters: none. Bit numbering follows FIPS 46-3: bit 1 is the MSB.

Ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a schedule; sampled only in IDLE
- key  in  [1:64]  DES key; sampled on the accepted start edge only; parity bits ignored
- next  in  1  consumer has taken the current Kn; advance to the next key
- busy  out  1  high in ISSUE and DONE
- out_valid  out  1  Kn and kidx are valid (ISSUE only)
- kidx  out  4  index of the current key, 15 down to 0; Kn = K(kidx+1)
- Kn  out  [1:48]  current subkey, PC-2 of the CD register
- done  out  1  single-cycle pulse after K1 is consumed

## Operation
- Registers:
  - CD[1:56]: C is [1:28], D is [29:56].
  - cnt[3:0]: keys issued so far.
  - state: IDLE, ISSUE or DONE.
- **IDLE**
  - busy=0, out_valid=0.
  - On start=1: CD <= {PC1_C(key), PC1_D(key)}, cnt <= 0, go to ISSUE.
  - The total left-rotation is 28, so C0D0 = C16D16 and the first issued key is K16 with no rotation.
- **ISSUE**
  - out_valid=1, kidx = 15 − cnt, Kn = PC2(CD).
  - When next=0: CD, cnt and Kn hold.
  - When next=1 and cnt<15: rotate C and D each right by RSHIFT[cnt+1], then cnt <= cnt+1.
  - When next=1 and cnt==15: go to DONE; CD is left unchanged.
- **RSHIFT table**, indexed by the next cnt value 1..15: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. This is the forward table 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 reversed, without its final entry.
- **Rotation**: C and D rotate independently, each 28 bits wide.
  - Right by 1: {X[28], X[1:27]}.
  - Right by 2: {X[27:28], X[1:26]}.
- **DONE**
  - done=1 for one cycle, busy=1, out_valid=0.
  - Always returns to IDLE.
- **Boundaries**
  - start in ISSUE or DONE is ignored and key is not sampled.
  - start in the cycle after done is accepted normally.
  - next in IDLE or DONE is ignored.
  - next held high continuously issues one key per cycle.
  - Reset mid-schedule aborts immediately: outputs go to their reset values and no done pulse is produced.
  - CD is never modified outside IDLE-accept and ISSUE-advance.
- **Reset values**
  - state=IDLE, CD=0, cnt=0.
  - busy=0, out_valid=0, done=0, kidx=15 (combinational 15 − cnt), Kn=0 (PC2 of zero).

## Timing
- Start accepted at edge N: out_valid=1 with K16 from edge N+1.
- With next tied high: K16..K1 are presented in cycles N+1..N+16, done=1 in cycle N+17, IDLE from N+18.
- Earliest back-to-back start is at edge N+18.
- Each next=1 sampled at an edge with out_valid=1 consumes exactly one key; the following key is visible after that edge.
- Kn is combinational from the CD register through PC-2, with no added pipeline stage. done, out_valid and busy are decoded from registered state.

## Structure
- Package des_pkg holds:
  - PC1_C, PC1_D and PC2 permutation functions, shared with the forward key schedule;
  - the 16-entry forward shift schedule constant;
  - the state encoding localparams.
- RSHIFT is derived from the forward schedule constant, not duplicated as a separate table.
- One natural sub-module is des_cd_rotr: combinational, inputs CD[1:56] and a 1-bit amount select (0 → right by 1, 1 → right by 2), output the rotated CD. The forward block can use a mirrored des_cd_rotl.
- FSM and counter live in the top module. Next-state and output decode use blocking combinational assignment; all registers use a single async-reset clocked process.

## Test plan
- **Reset defaults**: assert rst_n=0 with random inputs → out_valid=0, done=0, busy=0, Kn=0.
- **FIPS vector, next tied high**: key=0x133457799BBCDFF1, start pulse → cycle 1 Kn=0xCB3D8B0E17F5 (K16, kidx=15), cycle 2 Kn=0xBF918D3D3F0A (K15), cycle 16 Kn=0x1B02EFFC7072 (K1, kidx=0), cycle 17 done=1.
- **Stall**: same key, drop next for 5 cycles while kidx=8 → Kn, kidx and out_valid hold unchanged; sequence resumes and matches the reversed forward-model subkeys.
- **Cross-check**: 100 random keys, random next pattern → every issued Kn equals the forward-model subkey K(kidx+1); exactly 16 keys, then one done pulse.
- **Ignored start**: pulse start with a different key at kidx=10 → sequence unaffected; new start accepted at the cycle after done gives that key's K16.
- **Reset mid-operation**: deassert rst_n at kidx=7 → outputs return to reset values asynchronously, no done pulse; a fresh start then produces K16 correctly.
